// File: rtl/rot_pkg.sv
// Shared rotate helpers and state type for the rotator word-stream decoder.
// Contents:
//   MAX_W         widest data word the rotate helpers support
//   rotl_n/rotr_n width-generic rotate of the low w bits of x by k (k < w)
//   rdec_state_t  decoder state encoding
package rot_pkg;

    localparam int MAX_W = 64;
    localparam int IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } rdec_state_t;

    // Rotate the low w bits left by k; bits at and above w come back zero.
    // The index wraps by compare-and-subtract so a non power of two w is
    // handled correctly.
    function automatic logic [MAX_W-1:0] rotl_n(input logic [MAX_W-1:0] x,
                                                input int unsigned k,
                                                input int unsigned w);
        logic [MAX_W-1:0] r;
        int unsigned idx;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                idx = i + k;
                if (idx >= w) idx = idx - w;
                r[idx[IDX_W-1:0]] = x[i];
            end
        end
        return r;
    endfunction

    // Rotate the low w bits right by k; undoes a net left rotation of k.
    function automatic logic [MAX_W-1:0] rotr_n(input logic [MAX_W-1:0] x,
                                                input int unsigned k,
                                                input int unsigned w);
        logic [MAX_W-1:0] r;
        int unsigned idx;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                idx = i + k;
                if (idx >= w) idx = idx - w;
                r[i] = x[idx[IDX_W-1:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rotator_decoder.sv
// Receive end of the rotator word stream. Tracks the cumulative rotation
// offset, de-rotates each word back to the originally loaded value and flags
// any word that is not a single-step rotation of the previous one.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_sof        word qualifier / first word after a load
//   in_dir                 step that produced the word (0=left, 1=right)
//   in_data                rotated word
//   err_clr                clears the sticky error
//   out_valid/out_data     registered de-rotated word
//   out_offset             net left-rotation offset of the accepted word
//   locked                 high while tracking
//   err                    sticky consistency error
//   wrap_cnt               saturating count of offset wraps since last sof
module rotator_decoder
    import rot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic                     in_dir,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     err_clr,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_offset,
    output logic                     locked,
    output logic                     err,
    output logic [CNT_W-1:0]         wrap_cnt
);

    localparam int OFF_W = $clog2(WIDTH);
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(WIDTH - 1);

    rdec_state_t      state, state_n;
    logic [WIDTH-1:0] ref_word, ref_word_n;
    logic [OFF_W-1:0] offset, offset_n;
    logic             out_valid_n;
    logic [WIDTH-1:0] out_data_n;
    logic [OFF_W-1:0] out_offset_n;
    logic             err_n;
    logic [CNT_W-1:0] wrap_cnt_n;

    logic [OFF_W-1:0] step_off;
    logic             step_wrap;
    logic [WIDTH-1:0] cand;

    // Candidate offset for a single step. Explicit end-point compares keep
    // the arithmetic correct when WIDTH is not a power of two.
    always_comb begin
        step_off  = offset;
        step_wrap = 1'b0;
        if (in_dir) begin
            if (offset == '0) begin
                step_off  = OFF_MAX;
                step_wrap = 1'b1;
            end else begin
                step_off = offset - OFF_W'(1);
            end
        end else begin
            if (offset == OFF_MAX) begin
                step_off  = '0;
                step_wrap = 1'b1;
            end else begin
                step_off = offset + OFF_W'(1);
            end
        end
        cand = WIDTH'(rotr_n(MAX_W'(in_data), int'(step_off), WIDTH));
    end

    // Next-state and next-output logic. A sof word relocks from any state;
    // a mismatching word in TRACK drops to FAULT until the next sof. The err
    // update order makes a same-cycle mismatch win over err_clr.
    always_comb begin
        state_n      = state;
        ref_word_n   = ref_word;
        offset_n     = offset;
        out_valid_n  = 1'b0;
        out_data_n   = out_data;
        out_offset_n = out_offset;
        err_n        = err;
        wrap_cnt_n   = wrap_cnt;

        if (err_clr) err_n = 1'b0;

        if (in_valid) begin
            if (in_sof) begin
                state_n      = TRACK;
                ref_word_n   = in_data;
                offset_n     = '0;
                wrap_cnt_n   = '0;
                out_valid_n  = 1'b1;
                out_data_n   = in_data;
                out_offset_n = '0;
            end else if (state == TRACK) begin
                if (cand == ref_word) begin
                    offset_n     = step_off;
                    out_valid_n  = 1'b1;
                    out_data_n   = cand;
                    out_offset_n = step_off;
                    if (step_wrap && (wrap_cnt != '1))
                        wrap_cnt_n = wrap_cnt + CNT_W'(1);
                end else begin
                    err_n   = 1'b1;
                    state_n = FAULT;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ref_word   <= '0;
            offset     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_offset <= '0;
            err        <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            state      <= state_n;
            ref_word   <= ref_word_n;
            offset     <= offset_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            out_offset <= out_offset_n;
            err        <= err_n;
            wrap_cnt   <= wrap_cnt_n;
        end
    end

    assign locked = (state == TRACK);

endmodule

// File: tb/tb_rotator_decoder.sv
// Directed self-checking bench for rotator_decoder (WIDTH=8, CNT_W=8).
module tb_rotator_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_sof;
    logic       in_dir;
    logic [7:0] in_data;
    logic       err_clr;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_offset;
    logic       locked;
    logic       err;
    logic [7:0] wrap_cnt;

    int errors = 0;
    int checks = 0;

    rotator_decoder #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_dir(in_dir), .in_data(in_data), .err_clr(err_clr),
        .out_valid(out_valid), .out_data(out_data), .out_offset(out_offset),
        .locked(locked), .err(err), .wrap_cnt(wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one input cycle, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic v, input logic s, input logic d,
                                 input logic [7:0] data, input logic clr);
        in_valid = v;
        in_sof   = s;
        in_dir   = d;
        in_data  = data;
        err_clr  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        err_clr  = 1'b0;
    endtask

    logic [7:0]  w;
    logic [2:0]  exp_off;
    logic [11:0] dir_pat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_dir = 1'b0;
        in_data = '0; err_clr = 1'b0;

        // 1: reset, then valid words without sof are dropped
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_locked", 32'(locked), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_wrap", 32'(wrap_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 0, 0, 8'h24, 0);
        applyStimulus(1, 0, 1, 8'h5A, 0);
        checkOutput("idle_out_valid", 32'(out_valid), 0);
        checkOutput("idle_locked", 32'(locked), 0);
        checkOutput("idle_out_data", 32'(out_data), 0);
        checkOutput("idle_err", 32'(err), 0);

        // 2: sof 0x12 then 10 left steps
        applyStimulus(1, 1, 1, 8'h12, 0);
        checkOutput("sof12_valid", 32'(out_valid), 1);
        checkOutput("sof12_data", 32'(out_data), 32'h12);
        checkOutput("sof12_off", 32'(out_offset), 0);
        checkOutput("sof12_locked", 32'(locked), 1);
        w = 8'h12;
        exp_off = 3'd0;
        for (int i = 0; i < 10; i++) begin
            w = {w[6:0], w[7]};
            exp_off = exp_off + 3'd1;
            applyStimulus(1, 0, 0, w, 0);
            checkOutput("left_valid", 32'(out_valid), 1);
            checkOutput("left_data", 32'(out_data), 32'h12);
            checkOutput("left_off", 32'(out_offset), 32'(exp_off));
        end
        checkOutput("left_final_off", 32'(out_offset), 2);
        checkOutput("left_wrap", 32'(wrap_cnt), 1);
        checkOutput("left_err", 32'(err), 0);

        // 3: 9 right steps with gaps
        for (int i = 0; i < 9; i++) begin
            w = {w[0], w[7:1]};
            exp_off = exp_off - 3'd1;
            applyStimulus(1, 0, 1, w, 0);
            checkOutput("right_data", 32'(out_data), 32'h12);
            checkOutput("right_off", 32'(out_offset), 32'(exp_off));
            if (i == 3 || i == 6) begin
                applyStimulus(0, 0, 0, 8'hEE, 0);
                checkOutput("gap_valid", 32'(out_valid), 0);
                checkOutput("gap_locked", 32'(locked), 1);
            end
        end
        checkOutput("right_final_off", 32'(out_offset), 1);
        checkOutput("right_wrap", 32'(wrap_cnt), 2);
        checkOutput("right_err", 32'(err), 0);

        // 4: corrupt word forces FAULT; err_clr clears err only
        applyStimulus(1, 1, 0, 8'h80, 0);
        checkOutput("sof80_wrap", 32'(wrap_cnt), 0);
        applyStimulus(1, 0, 0, 8'h01, 0);
        checkOutput("f_step_data", 32'(out_data), 32'h80);
        checkOutput("f_step_off", 32'(out_offset), 1);
        applyStimulus(1, 0, 0, 8'hA5, 0);
        checkOutput("corrupt_err", 32'(err), 1);
        checkOutput("corrupt_valid", 32'(out_valid), 0);
        checkOutput("corrupt_locked", 32'(locked), 0);
        applyStimulus(1, 0, 0, 8'h02, 0);
        checkOutput("fault_drop_valid", 32'(out_valid), 0);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("clr_err", 32'(err), 0);
        checkOutput("clr_locked", 32'(locked), 0);
        // sof relocks from FAULT; then mismatch and err_clr together -> set wins
        applyStimulus(1, 0, 0, 8'h00, 0);
        applyStimulus(1, 1, 0, 8'h80, 0);
        checkOutput("relock_locked", 32'(locked), 1);
        applyStimulus(1, 0, 0, 8'h33, 1);
        checkOutput("setwins_err", 32'(err), 1);
        applyStimulus(1, 1, 0, 8'h80, 1);
        checkOutput("sofclr_err", 32'(err), 0);
        checkOutput("sofclr_locked", 32'(locked), 1);

        // 5: constant words, mixed directions
        dir_pat = 12'b1011_0011_1010;
        applyStimulus(1, 1, 0, 8'hFF, 0);
        exp_off = 3'd0;
        for (int i = 0; i < 12; i++) begin
            exp_off = dir_pat[i] ? exp_off - 3'd1 : exp_off + 3'd1;
            applyStimulus(1, 0, dir_pat[i], 8'hFF, 0);
            checkOutput("ff_data", 32'(out_data), 32'hFF);
            checkOutput("ff_off", 32'(out_offset), 32'(exp_off));
        end
        checkOutput("ff_err", 32'(err), 0);
        applyStimulus(1, 1, 1, 8'h00, 0);
        exp_off = 3'd0;
        for (int i = 0; i < 12; i++) begin
            exp_off = dir_pat[11-i] ? exp_off - 3'd1 : exp_off + 3'd1;
            applyStimulus(1, 0, dir_pat[11-i], 8'h00, 0);
            checkOutput("zero_valid", 32'(out_valid), 1);
            checkOutput("zero_off", 32'(out_offset), 32'(exp_off));
        end
        checkOutput("zero_data", 32'(out_data), 0);
        checkOutput("zero_err", 32'(err), 0);

        // 6: full left revolution, then async reset mid-frame
        applyStimulus(1, 1, 0, 8'h01, 0);
        w = 8'h01;
        for (int i = 0; i < 8; i++) begin
            w = {w[6:0], w[7]};
            applyStimulus(1, 0, 0, w, 0);
            checkOutput("rev_data", 32'(out_data), 32'h01);
        end
        checkOutput("rev_off", 32'(out_offset), 0);
        checkOutput("rev_wrap", 32'(wrap_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 0);
        checkOutput("arst_data", 32'(out_data), 0);
        checkOutput("arst_locked", 32'(locked), 0);
        checkOutput("arst_wrap", 32'(wrap_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 8'h02, 0);
        checkOutput("post_rst_valid", 32'(out_valid), 0);
        checkOutput("post_rst_locked", 32'(locked), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
